// File: rtl/one_six_demux.sv
`default_nettype none
// ============================================================================
// Module   : one_six_demux
// Brief    : Registered 1-to-6 demultiplexer. One input stream is steered to
//            six independent one-entry output lanes, selected either by
//            in_sel or by an internal round-robin pointer. Transfers aimed
//            at lanes 6/7 are discarded and counted.
// Revision : 1.0 - initial release
// ============================================================================
module one_six_demux #(
    parameter int WIDTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_sel,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              rr_mode,
    output logic [5:0]        out_valid,
    input  logic [5:0]        out_ready,
    output logic [WIDTH-1:0]  out_data0,
    output logic [WIDTH-1:0]  out_data1,
    output logic [WIDTH-1:0]  out_data2,
    output logic [WIDTH-1:0]  out_data3,
    output logic [WIDTH-1:0]  out_data4,
    output logic [WIDTH-1:0]  out_data5,
    output logic [2:0]        rr_ptr,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [DROP_W-1:0] c_drop_max = '1;
    localparam logic [2:0]        c_last_lane = 3'd5;

    logic [5:0]        valid_q;
    logic [5:0]        valid_d;
    logic [WIDTH-1:0]  data_q [6];
    logic [2:0]        rr_ptr_q;
    logic [2:0]        rr_ptr_d;
    logic [DROP_W-1:0] drop_q;
    logic [DROP_W-1:0] drop_d;

    logic [2:0]        w_eff;
    logic              w_eff_ok;
    logic [5:0]        w_hit;
    logic [5:0]        w_lane_ready;
    logic              w_accept;
    logic [5:0]        w_load;

    assign w_eff    = rr_mode ? rr_ptr_q : in_sel;
    assign w_eff_ok = (w_eff <= c_last_lane);

    // Per-lane decode: which lane is targeted and which lanes can take data
    generate
        for (genvar k = 0; k < 6; k++) begin : g_lane_dec
            assign w_hit[k]        = (w_eff == 3'(k));
            assign w_lane_ready[k] = !valid_q[k] | out_ready[k];
        end
    endgenerate

    // Invalid lanes always accept (and drop); real lanes accept when empty or draining
    always_comb begin
        in_ready = 1'b1;
        if (w_eff_ok) begin
            in_ready = |(w_hit & w_lane_ready);
        end
    end

    assign w_accept = in_valid & in_ready;
    assign w_load   = (w_accept && w_eff_ok) ? w_hit : 6'b0;

    // Lane valid next state: drain clears, reload on the same edge wins
    always_comb begin
        valid_d = (valid_q & ~out_ready) | w_load;
    end

    // Round-robin pointer and saturating drop counter next state
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        drop_d   = drop_q;
        if (w_accept && rr_mode) begin
            rr_ptr_d = (rr_ptr_q == c_last_lane) ? 3'd0 : rr_ptr_q + 3'd1;
        end
        if (w_accept && !w_eff_ok && (drop_q != c_drop_max)) begin
            drop_d = drop_q + 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            valid_q  <= 6'b0;
            rr_ptr_q <= 3'd0;
            drop_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            drop_q   <= drop_d;
        end
    end

    // Lane payload registers, loaded only when their lane accepts
    generate
        for (genvar k = 0; k < 6; k++) begin : g_lane_data
            always_ff @(posedge clk or posedge areset) begin
                if (areset) begin
                    data_q[k] <= '0;
                end else if (w_load[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    endgenerate

    assign out_valid = valid_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign out_data4 = data_q[4];
    assign out_data5 = data_q[5];
    assign rr_ptr    = rr_ptr_q;
    assign drop_cnt  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_one_six_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_one_six_demux
// Brief    : Self-checking bench for one_six_demux. A negedge monitor keeps a
//            per-lane scoreboard plus reference rr pointer and drop counter;
//            directed scenarios add targeted checks, then a random phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_one_six_demux;

    localparam int WIDTH  = 4;
    localparam int DROP_W = 8;

    logic              clk;
    logic              areset;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_sel;
    logic [WIDTH-1:0]  in_data;
    logic              rr_mode;
    logic [5:0]        out_valid;
    logic [5:0]        out_ready;
    logic [WIDTH-1:0]  out_data0, out_data1, out_data2;
    logic [WIDTH-1:0]  out_data3, out_data4, out_data5;
    logic [2:0]        rr_ptr;
    logic [DROP_W-1:0] drop_cnt;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [WIDTH-1:0]  sb_q [6][$];
    logic [2:0]        rr_m;
    logic [DROP_W-1:0] drop_m;

    one_six_demux #(.WIDTH(WIDTH), .DROP_W(DROP_W)) u_dut (
        .clk       (clk),
        .areset    (areset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .rr_mode   (rr_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_data4 (out_data4),
        .out_data5 (out_data5),
        .rr_ptr    (rr_ptr),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] lane_data(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            3:       return out_data3;
            4:       return out_data4;
            default: return out_data5;
        endcase
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 6; k++) sb_q[k].delete();
        rr_m   = 3'd0;
        drop_m = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare outputs with the model, then apply the edge to come
    always @(negedge clk) begin
        logic [5:0]       exp_v;
        logic [2:0]       eff;
        logic             exp_rdy;
        logic [WIDTH-1:0] front;
        if (!areset) begin
            for (int k = 0; k < 6; k++) exp_v[k] = (sb_q[k].size() != 0);
            check("out_valid", {26'b0, out_valid}, {26'b0, exp_v});
            check("rr_ptr", {29'b0, rr_ptr}, {29'b0, rr_m});
            check("drop_cnt", {24'b0, drop_cnt}, {24'b0, drop_m});
            eff     = rr_mode ? rr_m : in_sel;
            exp_rdy = (eff > 3'd5) ? 1'b1 : (!exp_v[eff] | out_ready[eff]);
            check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
            for (int k = 0; k < 6; k++) begin
                if (exp_v[k]) begin
                    front = sb_q[k][0];
                    check("lane_data", {28'b0, lane_data(k)}, {28'b0, front});
                    if (out_ready[k]) void'(sb_q[k].pop_front());
                end
            end
            if (in_valid && exp_rdy) begin
                if (eff <= 3'd5) sb_q[eff].push_back(in_data);
                else if (drop_m != '1) drop_m = drop_m + 1'b1;
                if (rr_mode) rr_m = (rr_m == 3'd5) ? 3'd0 : rr_m + 3'd1;
            end
        end
    end

    initial begin
        areset    = 1'b1;
        in_valid  = 1'b0;
        in_sel    = 3'd0;
        in_data   = '0;
        rr_mode   = 1'b0;
        out_ready = 6'b0;
        model_clear();
        repeat (3) tick();
        check("rst_valid", {26'b0, out_valid}, 32'h0);
        check("rst_data2", {28'b0, out_data2}, 32'h0);
        check("rst_rr", {29'b0, rr_ptr}, 32'h0);
        check("rst_drop", {24'b0, drop_cnt}, 32'h0);
        areset = 1'b0;
        tick();

        // single transfer to lane 2, then hold with consumer stalled
        in_sel = 3'd2; in_data = 4'hA; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {26'b0, out_valid}, 32'h04);
            check("hold_data2", {28'b0, out_data2}, 32'hA);
            tick();
        end
        in_valid = 1'b1;
        #1 check("full_ready", {31'b0, in_ready}, 32'h0);
        tick();

        // drain and reload on the same edge
        out_ready = 6'b000100; in_data = 4'h5;
        #1 check("pass_ready", {31'b0, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0;
        check("reload_valid", {31'b0, out_valid[2]}, 32'h1);
        check("reload_data2", {28'b0, out_data2}, 32'h5);
        tick();
        check("drain_valid", {31'b0, out_valid[2]}, 32'h0);

        // round-robin streaming
        rr_mode = 1'b1; out_ready = 6'h3F; in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        check("rr_end", {29'b0, rr_ptr}, 32'h2);
        tick();

        // round-robin stalled on a full lane
        out_ready = 6'h37; rr_mode = 1'b0; in_sel = 3'd3; in_data = 4'hC; in_valid = 1'b1;
        tick();
        rr_mode = 1'b1; in_data = 4'hD;
        tick();
        in_data = 4'hE;
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_ready", {31'b0, in_ready}, 32'h0);
            check("stall_rr", {29'b0, rr_ptr}, 32'h3);
            tick();
        end
        out_ready = 6'h3F;
        tick();
        in_valid = 1'b0;
        check("release_rr", {29'b0, rr_ptr}, 32'h4);
        check("release_data3", {28'b0, out_data3}, 32'hE);
        tick();

        // invalid lanes: 300 drops, counter saturates
        rr_mode = 1'b0; in_valid = 1'b1; in_sel = 3'd6;
        for (int i = 0; i < 300; i++) begin
            if (i == 150) in_sel = 3'd7;
            in_data = 4'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("drop_sat", {24'b0, drop_cnt}, 32'hFF);
        check("drop_valid", {26'b0, out_valid}, 32'h0);

        // asynchronous reset with lanes 0,4,5 full
        out_ready = 6'b0; in_valid = 1'b1;
        in_sel = 3'd0; in_data = 4'h1; tick();
        in_sel = 3'd4; in_data = 4'h4; tick();
        in_sel = 3'd5; in_data = 4'h7; tick();
        in_valid = 1'b0;
        check("pre_rst_valid", {26'b0, out_valid}, 32'h31);
        #2 areset = 1'b1;
        model_clear();
        #1;
        check("arst_valid", {26'b0, out_valid}, 32'h0);
        check("arst_rr", {29'b0, rr_ptr}, 32'h0);
        check("arst_drop", {24'b0, drop_cnt}, 32'h0);
        check("arst_data4", {28'b0, out_data4}, 32'h0);
        tick();
        areset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_valid", {26'b0, out_valid}, 32'h0);
        end

        // random traffic against the scoreboard
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 3'($urandom_range(0, 7));
            in_data   = 4'($urandom);
            out_ready = 6'($urandom);
            if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
